instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage that sits directly upstream of the decoder and drives the instruction ROM.
//  - Owns the PC and presents it to imem as a word address.
//  - Captures the returned word, same cycle, into a DEPTH-entry prefetch FIFO.
//  - Hands {pc, instr} to decode over a valid/ready handshake.
//  - Handles branch/PC-write redirects by flushing the FIFO and reloading the PC.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of 2, >= 2
//  RESET_PC  32'h0  PC loaded on reset; must be word aligned
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-low (0 = reset)
//  imem_addr    out  32  fetch address to imem; equals the current PC
//  imem_rd      in   32  instruction word from imem; combinational in imem_addr
//  redirect     in   1   branch taken / PC written; takes priority over everything else
//  redirect_pc  in   32  new PC; bits [1:0] ignored (forced 00)
//  out_valid    out  1   FIFO head valid
//  out_ready    in   1   decode accepts the head this cycle
//  out_instr    out  32  head instruction
//  out_pc       out  32  head PC
//  out_pcplus8  out  32  out_pc + 8 (ARM PC-read value), modulo 2^32
//  halted       out  1   fetch stopped on a self-loop (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pc=RESET_PC, count=0, rd/wr pointers=0, halted=0.
//    This overrides any in-flight state, including a full FIFO.
//  - Reset output values: out_valid=0, imem_addr=RESET_PC.
//  - Definitions:
//    pop   = out_valid & out_ready
//    space = (count < DEPTH) | pop
//    push  = space & ~halted & ~redirect
//  - On push: write {pc, imem_rd} at wr_ptr; pc <= pc + 4. PC wraps 0xFFFFFFFC -> 0x0.
//  - On pop: rd_ptr advances. Pointers wrap modulo DEPTH.
//  - count' = count + push - pop. Simultaneous push and pop when full is allowed; count stays DEPTH.
//  - out_valid = (count != 0) & ~redirect.
//    out_instr/out_pc are read combinationally from the head entry.
//  - Latency: a word fetched at edge N is visible at the head from cycle N+1 when the FIFO was empty.
//    Steady state with out_ready=1 is 1 instruction per cycle.
//  - Full (count==DEPTH, no pop): no push; pc and imem_addr hold.
//  - Empty: out_valid=0; out_instr/out_pc are don't-care.
//  - Redirect at an edge:
//    - count, rd_ptr and wr_ptr are cleared to 0.
//    - pc <= {redirect_pc[31:2], 2'b00}; halted <= 0.
//    - No push and no pop occur that cycle.
//    - First new instruction is at out_valid 2 cycles after the redirect edge.
//  - Redirect while reset is active is ignored; reset wins.
// CONFIGURATION
//  IFQ_HALT_DETECT_EN defined:
//  - When a pushed imem_rd == 32'hEAFFFFFE (B to self), halted <= 1 at that edge.
//  - The self-loop instruction is enqueued exactly once; after that, no further pushes occur.
//  - pc holds at the loop address + 4.
//  - halted clears only on redirect or reset.
//  IFQ_HALT_DETECT_EN undefined:
//  - halted is tied to 0; fetch continues indefinitely.
// TESTING
//  1 Release reset, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle; out_instr matches ROM;
//    out_pcplus8 = out_pc+8.
//  2 out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds 0x10;
//    raise out_ready -> PCs 0x0..0xC delivered in order, then 0x10, with no loss or duplicate.
//  3 FIFO holding 3 entries, redirect=1, redirect_pc=0x38 for one cycle
//    -> next cycle out_valid=0, imem_addr=0x38; the cycle after: out_pc=0x38.
//  4 redirect_pc=0x3A -> imem_addr=0x38; redirect and out_ready=1 in the same cycle -> no pop counted.
//  5 ROM word 0xEAFFFFFE at 0x34, IFQ_HALT_DETECT_EN defined -> halted=1 after that push;
//    imem_addr stays 0x38; exactly one entry has out_pc=0x34; redirect to 0x0 clears halted.
//    With the macro undefined, imem_addr advances past 0x38.
//  6 FIFO full, reset=0 for one cycle -> next cycle out_valid=0, imem_addr=RESET_PC;
//    fetch resumes from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, drives imem and buffers {pc, instr} for decode.
// Define IFQ_HALT_DETECT_EN to stop fetching after a B-to-self (0xEAFFFFFE).
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus8,
    output logic        halted
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    ifq_entry_t    mem [DEPTH];
    ifq_entry_t    head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [31:0]   pc;
    logic          pop;
    logic          push;
    logic          space;

    assign imem_addr = pc;
    assign head      = mem[rd_ptr];

    assign out_valid   = (count != '0) & ~redirect;
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign out_pcplus8 = head.pc + 32'd8;

    // A pop frees a slot this cycle, so a full queue can still accept.
    assign pop   = out_valid & out_ready;
    assign space = (count < FULL) | pop;
    assign push  = space & ~halted & ~redirect;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc & 32'hFFFF_FFFC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: pc, instr: imem_rd};
        end
    end

`ifdef IFQ_HALT_DETECT_EN
    localparam logic [31:0] SELF_LOOP = 32'hEAFF_FFFE;

    logic halt_q;

    // The loop word itself is enqueued; only later pushes are blocked.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_q <= 1'b0;
        end else if (redirect) begin
            halt_q <= 1'b0;
        end else if (push && (imem_rd == SELF_LOOP)) begin
            halt_q <= 1'b1;
        end
    end

    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-level reference model plus
// directed scenarios with literal expectations.
module tb_instr_fetch_queue;

`ifdef IFQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus8;
    logic        halted;
    logic        loop_en;

    int n_checks;
    int n_fail;

    ent_t        mq[$];
    logic [31:0] mpc;
    logic        mhalt;
    bit          m_live;
    logic [31:0] got[$];

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus8 (out_pcplus8),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom(input logic [31:0] a, input logic le);
        if (le && a == 32'h34) return 32'hEAFF_FFFE;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    always_comb imem_rd = rom(imem_addr, loop_en);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: advance one clock edge using queue semantics.
    always @(posedge clk) begin
        bit   m_pop;
        bit   m_push;
        ent_t e;
        if (!reset) begin
            mq.delete();
            mpc    = 32'h0;
            mhalt  = 1'b0;
            m_live = 1'b1;
        end else if (m_live && redirect) begin
            mq.delete();
            mpc   = redirect_pc & 32'hFFFF_FFFC;
            mhalt = 1'b0;
        end else if (m_live) begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = !mhalt && ((mq.size() < 4) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.pc    = mpc;
                e.instr = rom(mpc, loop_en);
                mq.push_back(e);
                if (HALT_EN && e.instr == 32'hEAFF_FFFE) mhalt = 1'b1;
                mpc = mpc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit ev;
        if (m_live) begin
            ev = (mq.size() != 0) && !redirect;
            chk("imem_addr", imem_addr, mpc);
            chk("halted", {31'd0, halted}, {31'd0, mhalt});
            chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
            if (ev) begin
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_instr", out_instr, mq[0].instr);
                chk("out_pcplus8", out_pcplus8, mq[0].pc + 32'd8);
            end
            if (out_valid && out_ready) got.push_back(out_pc);
        end
    end

    task automatic cyc(input logic rst, input logic rdir,
                       input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset       = rst;
        redirect    = rdir;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int          gsz;
        int          n34;
        logic [31:0] pk;
        n_checks    = 0;
        n_fail      = 0;
        m_live      = 1'b0;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        loop_en     = 1'b0;

        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // 1: streaming from reset
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            pk = 32'(4 * k);
            chk("t1_valid", {31'd0, out_valid}, 32'd1);
            chk("t1_pc", out_pc, pk);
            chk("t1_instr", out_instr, rom(pk, 1'b0));
            chk("t1_pc8", out_pcplus8, pk + 32'd8);
        end

        // 2: stall until full, then drain in order
        cyc(1'b1, 1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_full_addr", imem_addr, 32'h10);
        chk("t2_full_pc", out_pc, 32'h0);
        got.delete();
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t2_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) chk("t2_order", got[k], 32'(4 * k));
        end

        // 3: redirect with three entries queued
        cyc(1'b1, 1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h38, 1'b0);
        chk("t3_rd_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_rd_addr", imem_addr, 32'hC);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_n1_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_n1_addr", imem_addr, 32'h38);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_n2_pc", out_pc, 32'h38);

        // 4: unaligned redirect alongside out_ready
        gsz = got.size();
        cyc(1'b1, 1'b1, 32'h3A, 1'b1);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_nopop", 32'(got.size()), 32'(gsz));
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_addr", imem_addr, 32'h38);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_pc", out_pc, 32'h38);

        // 5: self-loop word at 0x34
        loop_en = 1'b1;
        cyc(1'b1, 1'b1, 32'h30, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_halted", {31'd0, halted}, HALT_EN ? 32'd1 : 32'd0);
        chk("t5_addr", imem_addr, HALT_EN ? 32'h38 : 32'h40);
        got.delete();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        n34 = 0;
        foreach (got[i]) if (got[i] == 32'h34) n34++;
        chk("t5_once", 32'(n34), 32'd1);
        chk("t5_size", 32'(got.size()), HALT_EN ? 32'd2 : 32'd4);
        if (got.size() >= 2) begin
            chk("t5_first", got[0], 32'h30);
            chk("t5_second", got[1], 32'h34);
        end
        chk("t5_drained", {31'd0, out_valid}, HALT_EN ? 32'd0 : 32'd1);
        loop_en = 1'b0;
        cyc(1'b1, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_clr_halt", {31'd0, halted}, 32'd0);
        chk("t5_clr_addr", imem_addr, 32'h0);

        // 6: reset over a full queue, with a competing redirect
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_full_addr", imem_addr, 32'h10);
        chk("t6_full_valid", {31'd0, out_valid}, 32'd1);
        cyc(1'b0, 1'b1, 32'h80, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        got.delete();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_resume", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk("t6_order", got[k], 32'(4 * k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
